div_sched: RTL and testbench

Front-end scheduler for the shared iterative `divider`. It accepts divide uops from issue through a valid/ready port and buffers them in a small in-order queue. It launches one uop at a time into the divider and holds each result in a one-entry writeback buffer until writeback acknowledges it. On pipeline flush it kills queued and in-flight work.

---
 rtl/div_sched.sv | 109 ++++++++++
 tb/tb_div_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sched.sv
// div_sched: queues divide uops, launches one at a time into the shared divider and buffers each result for writeback
`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 6
`endif
`ifndef LG_HILO_PRF_ENTRIES
`define LG_HILO_PRF_ENTRIES 6
`endif
module div_sched #(
  parameter int LG_W = 5,
  parameter int LG_Q = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [(1<<LG_W)-1:0]              req_srcA,
  input  logic [(1<<LG_W)-1:0]              req_srcB,
  input  logic                              req_is_signed,
  input  logic [`LG_ROB_ENTRIES-1:0]        req_rob_ptr,
  input  logic [`LG_HILO_PRF_ENTRIES-1:0]   req_hilo_ptr,
  input  logic                              flush,
  output logic                              div_start,
  output logic [(1<<LG_W)-1:0]              div_srcA,
  output logic [(1<<LG_W)-1:0]              div_srcB,
  output logic                              div_is_signed,
  output logic [`LG_ROB_ENTRIES-1:0]        div_rob_ptr,
  output logic [`LG_HILO_PRF_ENTRIES-1:0]   div_hilo_ptr,
  input  logic                              div_ready,
  input  logic                              div_complete,
  input  logic [(2<<LG_W)-1:0]              div_y,
  input  logic [`LG_ROB_ENTRIES-1:0]        div_rob_ptr_out,
  input  logic [`LG_HILO_PRF_ENTRIES-1:0]   div_hilo_ptr_out,
  output logic                              wb_valid,
  input  logic                              wb_ack,
  output logic [(2<<LG_W)-1:0]              wb_y,
  output logic [`LG_ROB_ENTRIES-1:0]        wb_rob_ptr,
  output logic [`LG_HILO_PRF_ENTRIES-1:0]   wb_hilo_ptr,
  output logic                              busy
);
  localparam int W = 1 << LG_W;
  localparam int DEPTH = 1 << LG_Q;
  localparam int RW = `LG_ROB_ENTRIES;
  localparam int HW = `LG_HILO_PRF_ENTRIES;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;
  state_t state, state_n;
  logic [W-1:0] q_a [DEPTH];
  logic [W-1:0] q_b [DEPTH];
  logic q_s [DEPTH];
  logic [RW-1:0] q_rob [DEPTH];
  logic [HW-1:0] q_hilo [DEPTH];
  logic [LG_Q-1:0] head, tail;
  logic [LG_Q:0] count;
  logic r_killed, enq, capture;
  assign req_ready = !count[LG_Q];
  assign enq = req_valid && req_ready && !flush;
  assign div_start = state == LAUNCH;
  assign capture = state == WAIT && div_complete && !r_killed && !flush;
  assign busy = count != '0 || state != IDLE || wb_valid;
  assign div_srcA = q_a[head];
  assign div_srcB = q_b[head];
  assign div_is_signed = q_s[head];
  assign div_rob_ptr = q_rob[head];
  assign div_hilo_ptr = q_hilo[head];
  always_comb begin
    state_n = state == IDLE ? ((count != '0 && !wb_valid && div_ready && !flush) ? LAUNCH : IDLE) :
              state == LAUNCH ? WAIT :
              div_complete ? IDLE : WAIT;
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      q_a[tail] <= req_srcA;
      q_b[tail] <= req_srcB;
      q_s[tail] <= req_is_signed;
      q_rob[tail] <= req_rob_ptr;
      q_hilo[tail] <= req_hilo_ptr;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (div_start) head <= head + 1'b1;
      count <= count + (LG_Q+1)'(enq) - (LG_Q+1)'(div_start);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      r_killed <= 1'b0;
      wb_valid <= 1'b0;
      wb_y <= '0;
      wb_rob_ptr <= '0;
      wb_hilo_ptr <= '0;
    end else begin
      state <= state_n;
      if (state == WAIT && div_complete) r_killed <= 1'b0;
      else if (flush && state != IDLE) r_killed <= 1'b1;
      if (capture) begin
        wb_valid <= 1'b1;
        wb_y <= div_y;
        wb_rob_ptr <= div_rob_ptr_out;
        wb_hilo_ptr <= div_hilo_ptr_out;
      end else if (flush || wb_ack) wb_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: directed and randomized bench with a behavioural divider and an in-order result scoreboard
`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 6
`endif
`ifndef LG_HILO_PRF_ENTRIES
`define LG_HILO_PRF_ENTRIES 6
`endif
module tb_div_sched;
  localparam int LG_W = 5;
  localparam int W = 32;
  localparam int LG_Q = 2;
  localparam int RW = `LG_ROB_ENTRIES;
  localparam int HW = `LG_HILO_PRF_ENTRIES;
  localparam int LAT = W + 2;

  logic clk = 0, reset = 1, req_valid = 0, req_is_signed = 0, flush = 0, wb_ack = 0;
  logic [W-1:0] req_srcA = 0, req_srcB = 1;
  logic [RW-1:0] req_rob_ptr = 0;
  logic [HW-1:0] req_hilo_ptr = 0;
  logic req_ready, div_start, div_is_signed, div_ready, div_complete, wb_valid, busy;
  logic [W-1:0] div_srcA, div_srcB;
  logic [RW-1:0] div_rob_ptr, div_rob_ptr_out, wb_rob_ptr, d_rob;
  logic [HW-1:0] div_hilo_ptr, div_hilo_ptr_out, wb_hilo_ptr, d_hilo;
  logic [2*W-1:0] div_y, wb_y, d_y;
  logic d_busy;
  int d_cnt;

  typedef struct {
    logic [2*W-1:0] y;
    logic [RW-1:0] rob;
    logic [HW-1:0] hilo;
  } res_t;
  res_t exp_q[$];
  res_t mon_e;

  int checks = 0, errors = 0, cyc = 0, starts = 0, wb_rises = 0, last_start = 0, gap = 0;
  bit wb_prev = 0, ack_rand = 0;

  div_sched #(.LG_W(LG_W), .LG_Q(LG_Q)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_srcA(req_srcA), .req_srcB(req_srcB), .req_is_signed(req_is_signed),
    .req_rob_ptr(req_rob_ptr), .req_hilo_ptr(req_hilo_ptr), .flush(flush),
    .div_start(div_start), .div_srcA(div_srcA), .div_srcB(div_srcB),
    .div_is_signed(div_is_signed), .div_rob_ptr(div_rob_ptr), .div_hilo_ptr(div_hilo_ptr),
    .div_ready(div_ready), .div_complete(div_complete), .div_y(div_y),
    .div_rob_ptr_out(div_rob_ptr_out), .div_hilo_ptr_out(div_hilo_ptr_out),
    .wb_valid(wb_valid), .wb_ack(wb_ack), .wb_y(wb_y), .wb_rob_ptr(wb_rob_ptr),
    .wb_hilo_ptr(wb_hilo_ptr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Divider convention: quotient truncates toward zero, remainder is the magnitude remainder.
  function automatic logic [2*W-1:0] div_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] ma, mb, q, r;
    ma = (s && a[W-1]) ? -a : a;
    mb = (s && b[W-1]) ? -b : b;
    q = ma / mb;
    r = ma % mb;
    if (s && (a[W-1] ^ b[W-1])) q = -q;
    return {r, q};
  endfunction

  assign div_ready = !d_busy;
  assign div_complete = d_busy && d_cnt == 0;
  assign div_y = d_y;
  assign div_rob_ptr_out = d_rob;
  assign div_hilo_ptr_out = d_hilo;
  always @(posedge clk) begin
    if (reset) begin
      d_busy <= 0;
      d_cnt <= 0;
    end else if (div_start) begin
      d_busy <= 1;
      d_cnt <= LAT - 1;
      d_y <= div_ref(div_srcA, div_srcB, div_is_signed);
      d_rob <= div_rob_ptr;
      d_hilo <= div_hilo_ptr;
    end else if (div_complete) d_busy <= 0;
    else if (d_busy) d_cnt <= d_cnt - 1;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (div_start) begin
      gap = cyc - last_start;
      last_start = cyc;
      starts++;
    end
    if (wb_valid && !wb_prev) begin
      wb_rises++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL wb_unexpected got y=%0h expected no result", wb_y);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("wb_y", wb_y, mon_e.y);
        chk("wb_rob", wb_rob_ptr, mon_e.rob);
        chk("wb_hilo", wb_hilo_ptr, mon_e.hilo);
      end
    end
    wb_prev = wb_valid;
    if (ack_rand) wb_ack = 1'($urandom_range(0, 1));
  endtask

  task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [RW-1:0] rob, input logic [HW-1:0] hilo, output bit acc);
    res_t e;
    req_srcA = a; req_srcB = b; req_is_signed = s; req_rob_ptr = rob; req_hilo_ptr = hilo;
    req_valid = 1;
    acc = req_ready && !flush;
    step();
    req_valid = 0;
    if (acc) begin
      e.y = div_ref(a, b, s);
      e.rob = rob;
      e.hilo = hilo;
      exp_q.push_back(e);
    end
  endtask

  task automatic rnd_offer(output bit acc);
    logic [W-1:0] a, b;
    a = $urandom;
    b = $urandom_range(0, 1) ? W'($urandom_range(1, 100)) : W'($urandom);
    if (b == 0) b = 1;
    offer(a, b, 1'($urandom_range(0, 1)), RW'($urandom), HW'($urandom), acc);
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max) begin step(); n++; end
    chk("drain_timeout", n < max, 1);
  endtask

  task automatic wait_wb(input int max);
    int n = 0;
    while (!wb_valid && n < max) begin step(); n++; end
    chk("wb_timeout", n < max, 1);
  endtask

  initial begin
    bit acc;
    int n, s0, w0, acc_cnt;
    logic [2*W-1:0] y0;
    bit stable;
    repeat (3) step();
    chk("rst_div_start", div_start, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_wb_y", wb_y, 0);
    chk("rst_wb_rob", wb_rob_ptr, 0);
    chk("rst_wb_hilo", wb_hilo_ptr, 0);
    reset = 0;
    step();

    // single unsigned op; cycle 0 is the first cycle the entry is held
    s0 = starts;
    offer(100, 7, 0, 5, 9, acc);
    chk("c0_busy", busy, 1);
    chk("c0_div_start", div_start, 0);
    chk("c0_head_a", div_srcA, 100);
    chk("c0_head_b", div_srcB, 7);
    step();
    chk("c1_div_start", div_start, 1);
    step();
    chk("c2_div_start", div_start, 0);
    n = 2;
    while (!wb_valid && n < 200) begin step(); n++; end
    chk("wb_cycle", n, 36);
    chk("single_y", wb_y, {32'd2, 32'd14});
    chk("single_rob", wb_rob_ptr, 5);
    chk("single_hilo", wb_hilo_ptr, 9);
    chk("single_starts", starts - s0, 1);
    wb_ack = 1;
    step();
    wb_ack = 0;
    chk("ack_clears", wb_valid, 0);

    // signed and unsigned -100/7
    offer(32'hFFFFFF9C, 7, 1, 11, 12, acc);
    wait_wb(100);
    chk("signed_y", wb_y, {32'd2, 32'hFFFFFFF2});
    wb_ack = 1;
    wait_drain(100);
    offer(32'hFFFFFF9C, 7, 0, 13, 14, acc);
    wait_drain(100);
    chk("unsigned_y", wb_y, {32'd2, 32'h24924916});

    // fill with ack tied high
    s0 = starts;
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin rnd_offer(acc); acc_cnt += int'(acc); end
    chk("fill_accepted", acc_cnt, 5);
    chk("fill_ready_low", req_ready, 0);
    rnd_offer(acc);
    chk("fill_drop_when_full", acc, 0);
    chk("fill_ready_still_low", req_ready, 0);
    wait_drain(400);
    chk("fill_starts", starts - s0, 5);
    chk("throughput_gap", gap, W + 5);

    // backpressure
    wb_ack = 0;
    rnd_offer(acc);
    rnd_offer(acc);
    wait_wb(100);
    y0 = wb_y;
    s0 = starts;
    stable = 1;
    repeat (100) begin step(); if (wb_y !== y0 || !wb_valid) stable = 0; end
    chk("bp_wb_stable", stable, 1);
    chk("bp_no_launch", starts - s0, 0);
    wb_ack = 1;
    step();
    wb_ack = 0;
    chk("bp_t1_wb_valid", wb_valid, 0);
    chk("bp_t1_div_start", div_start, 0);
    step();
    chk("bp_t2_div_start", div_start, 1);
    wb_ack = 1;
    wait_drain(100);

    // flush in WAIT with two queued
    rnd_offer(acc);
    rnd_offer(acc);
    rnd_offer(acc);
    repeat (5) step();
    chk("fw_busy", busy, 1);
    flush = 1;
    step();
    flush = 0;
    exp_q.delete();
    chk("fw_ready", req_ready, 1);
    s0 = starts;
    w0 = wb_rises;
    repeat (60) step();
    chk("fw_no_wb", wb_rises - w0, 0);
    chk("fw_no_launch", starts - s0, 0);
    chk("fw_idle", busy, 0);
    rnd_offer(acc);
    wait_drain(100);
    chk("fw_after_wb", wb_rises - w0, 1);

    // flush coincident with div_start, plus an enqueue offered in that cycle
    s0 = starts;
    w0 = wb_rises;
    rnd_offer(acc);
    n = 0;
    while (!div_start && n < 10) begin step(); n++; end
    chk("fs_launch_seen", div_start, 1);
    flush = 1;
    rnd_offer(acc);
    flush = 0;
    chk("fs_flush_enq_dropped", acc, 0);
    exp_q.delete();
    repeat (50) step();
    chk("fs_no_wb", wb_rises - w0, 0);
    chk("fs_one_launch", starts - s0, 1);
    chk("fs_idle", busy, 0);

    // flush coincident with div_complete
    w0 = wb_rises;
    rnd_offer(acc);
    n = 0;
    while (!div_complete && n < 60) begin step(); n++; end
    chk("fc_complete_seen", div_complete, 1);
    flush = 1;
    step();
    flush = 0;
    exp_q.delete();
    chk("fc_wb_valid", wb_valid, 0);
    repeat (5) step();
    chk("fc_no_wb", wb_rises - w0, 0);
    rnd_offer(acc);
    wait_drain(100);
    chk("fc_next_ok", wb_rises - w0, 1);

    // reset mid-divide
    rnd_offer(acc);
    rnd_offer(acc);
    repeat (15) step();
    reset = 1;
    step();
    exp_q.delete();
    chk("mr_div_start", div_start, 0);
    chk("mr_wb_valid", wb_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_req_ready", req_ready, 1);
    chk("mr_wb_y", wb_y, 0);
    reset = 0;
    step();
    rnd_offer(acc);
    wait_drain(100);

    // randomized traffic with random acknowledge
    ack_rand = 1;
    for (int i = 0; i < 20; i++) begin
      rnd_offer(acc);
      repeat ($urandom_range(0, 3)) step();
    end
    wait_wb(300);
    ack_rand = 0;
    wb_ack = 1;
    wait_drain(2000);
    chk("rand_all_returned", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
